// File: rtl/pa_pmp_chk_pipe.sv
// Registered PMP permission checker for the IFU and LSU request channels.
// Resolves the governing entry by static priority and keeps a sticky record of the first deny.
module pa_pmp_chk_pipe #(
   parameter int unsigned NUM_ENTRY  = 8,
   parameter int unsigned ADDR_WIDTH = 32,
   localparam int unsigned IDX_W     = $clog2(NUM_ENTRY)
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic [NUM_ENTRY-1:0]  regs_comp_lock,
   input  logic [NUM_ENTRY-1:0]  regs_comp_read,
   input  logic [NUM_ENTRY-1:0]  regs_comp_write,
   input  logic [NUM_ENTRY-1:0]  regs_comp_excut,
   input  logic                  ifu_pmp_req_vld,
   output logic                  ifu_pmp_req_rdy,
   input  logic                  ifu_pmp_req_mach,
   input  logic [NUM_ENTRY-1:0]  ifu_pmp_req_hit,
   input  logic [ADDR_WIDTH-1:0] ifu_pmp_req_addr,
   output logic                  ifu_pmp_rsp_vld,
   input  logic                  ifu_pmp_rsp_rdy,
   output logic                  ifu_pmp_rsp_deny,
   output logic                  ifu_pmp_rsp_hit,
   output logic [IDX_W-1:0]      ifu_pmp_rsp_idx,
   input  logic                  lsu_pmp_req_vld,
   output logic                  lsu_pmp_req_rdy,
   input  logic                  lsu_pmp_req_mach,
   input  logic [NUM_ENTRY-1:0]  lsu_pmp_req_hit,
   input  logic [ADDR_WIDTH-1:0] lsu_pmp_req_addr,
   input  logic                  lsu_pmp_req_st,
   output logic                  lsu_pmp_rsp_vld,
   input  logic                  lsu_pmp_rsp_rdy,
   output logic                  lsu_pmp_rsp_deny,
   output logic                  lsu_pmp_rsp_hit,
   output logic [IDX_W-1:0]      lsu_pmp_rsp_idx,
   input  logic                  fault_clr,
   output logic                  fault_vld,
   output logic                  fault_src,
   output logic                  fault_st,
   output logic                  fault_no_hit,
   output logic [IDX_W-1:0]      fault_idx,
   output logic [ADDR_WIDTH-1:0] fault_addr,
   output logic                  fault_ovf
);

   // Lowest set bit wins; returns 0 for an empty vector.
   function automatic logic [IDX_W-1:0] first_hit(input logic [NUM_ENTRY-1:0] v);
      first_hit = '0;
      for (int i = int'(NUM_ENTRY) - 1; i >= 0; i--) begin
         if (v[i]) first_hit = IDX_W'(i);
      end
   endfunction

   logic [IDX_W-1:0] ifu_idx_c, lsu_idx_c;
   logic             ifu_any_c, lsu_any_c;
   logic             ifu_deny_c, lsu_deny_c, lsu_perm_c;
   logic             ifu_acc_c, lsu_acc_c;
   logic             ifu_fd_c, lsu_fd_c;

   always_comb begin
      ifu_idx_c  = first_hit(ifu_pmp_req_hit);
      lsu_idx_c  = first_hit(lsu_pmp_req_hit);
      ifu_any_c  = |ifu_pmp_req_hit;
      lsu_any_c  = |lsu_pmp_req_hit;
      lsu_perm_c = lsu_pmp_req_st ? regs_comp_write[lsu_idx_c] : regs_comp_read[lsu_idx_c];
      ifu_deny_c = ifu_any_c
                 ? ((ifu_pmp_req_mach & regs_comp_lock[ifu_idx_c] & ~regs_comp_excut[ifu_idx_c]) |
                    (~ifu_pmp_req_mach & ~regs_comp_excut[ifu_idx_c]))
                 : ~ifu_pmp_req_mach;
      lsu_deny_c = lsu_any_c
                 ? ((lsu_pmp_req_mach & regs_comp_lock[lsu_idx_c] & ~lsu_perm_c) |
                    (~lsu_pmp_req_mach & ~lsu_perm_c))
                 : ~lsu_pmp_req_mach;
   end

   assign ifu_pmp_req_rdy = ~ifu_pmp_rsp_vld | ifu_pmp_rsp_rdy;
   assign lsu_pmp_req_rdy = ~lsu_pmp_rsp_vld | lsu_pmp_rsp_rdy;
   assign ifu_acc_c       = ifu_pmp_req_vld & ifu_pmp_req_rdy;
   assign lsu_acc_c       = lsu_pmp_req_vld & lsu_pmp_req_rdy;
   assign ifu_fd_c        = ifu_acc_c & ifu_deny_c;
   assign lsu_fd_c        = lsu_acc_c & lsu_deny_c;

   // One-entry IFU response register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ifu_pmp_rsp_vld  <= 1'b0;
         ifu_pmp_rsp_deny <= 1'b0;
         ifu_pmp_rsp_hit  <= 1'b0;
         ifu_pmp_rsp_idx  <= '0;
      end else if (ifu_acc_c) begin
         ifu_pmp_rsp_vld  <= 1'b1;
         ifu_pmp_rsp_deny <= ifu_deny_c;
         ifu_pmp_rsp_hit  <= ifu_any_c;
         ifu_pmp_rsp_idx  <= ifu_idx_c;
      end else if (ifu_pmp_rsp_rdy) begin
         ifu_pmp_rsp_vld  <= 1'b0;
      end
   end

   // One-entry LSU response register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         lsu_pmp_rsp_vld  <= 1'b0;
         lsu_pmp_rsp_deny <= 1'b0;
         lsu_pmp_rsp_hit  <= 1'b0;
         lsu_pmp_rsp_idx  <= '0;
      end else if (lsu_acc_c) begin
         lsu_pmp_rsp_vld  <= 1'b1;
         lsu_pmp_rsp_deny <= lsu_deny_c;
         lsu_pmp_rsp_hit  <= lsu_any_c;
         lsu_pmp_rsp_idx  <= lsu_idx_c;
      end else if (lsu_pmp_rsp_rdy) begin
         lsu_pmp_rsp_vld  <= 1'b0;
      end
   end

   // Sticky fault record; a clear in the same cycle as a deny lets the deny be captured
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         fault_vld    <= 1'b0;
         fault_src    <= 1'b0;
         fault_st     <= 1'b0;
         fault_no_hit <= 1'b0;
         fault_idx    <= '0;
         fault_addr   <= '0;
         fault_ovf    <= 1'b0;
      end else if (ifu_fd_c | lsu_fd_c) begin
         if (!fault_vld || fault_clr) begin
            fault_vld    <= 1'b1;
            fault_src    <= lsu_fd_c;
            fault_st     <= lsu_fd_c & lsu_pmp_req_st;
            fault_no_hit <= lsu_fd_c ? ~lsu_any_c : ~ifu_any_c;
            fault_idx    <= lsu_fd_c ? lsu_idx_c : ifu_idx_c;
            fault_addr   <= lsu_fd_c ? lsu_pmp_req_addr : ifu_pmp_req_addr;
            fault_ovf    <= ifu_fd_c & lsu_fd_c;
         end else begin
            fault_ovf    <= 1'b1;
         end
      end else if (fault_clr) begin
         fault_vld <= 1'b0;
         fault_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pa_pmp_chk_pipe.sv
// Bench for pa_pmp_chk_pipe: directed vector table, corner-case sequences and
// randomized traffic against a cycle-level reference model.
module tb_pa_pmp_chk_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  lock, rd, wr, ex;
   logic        ifu_vld, ifu_mach, ifu_rsp_rdy;
   logic [7:0]  ifu_hit;
   logic [31:0] ifu_addr;
   logic        lsu_vld, lsu_mach, lsu_rsp_rdy, lsu_st;
   logic [7:0]  lsu_hit;
   logic [31:0] lsu_addr;
   logic        fclr;
   logic        ifu_req_rdy, ifu_rsp_vld, ifu_rsp_deny, ifu_rsp_hit;
   logic [2:0]  ifu_rsp_idx;
   logic        lsu_req_rdy, lsu_rsp_vld, lsu_rsp_deny, lsu_rsp_hit;
   logic [2:0]  lsu_rsp_idx;
   logic        f_vld, f_src, f_st, f_nh, f_ovf;
   logic [2:0]  f_idx;
   logic [31:0] f_addr;

   // 16-entry instance for the top-index corner
   logic [15:0] w_perm, w_hit;
   logic        w_vld;
   logic        w_ifu_req_rdy, w_ifu_rsp_vld, w_ifu_rsp_deny, w_ifu_rsp_hit;
   logic [3:0]  w_ifu_rsp_idx;
   logic        w_lsu_req_rdy, w_lsu_rsp_vld, w_lsu_rsp_deny, w_lsu_rsp_hit;
   logic [3:0]  w_lsu_rsp_idx;
   logic        w_f_vld, w_f_src, w_f_st, w_f_nh, w_f_ovf;
   logic [3:0]  w_f_idx;
   logic [31:0] w_f_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pa_pmp_chk_pipe #(.NUM_ENTRY(8), .ADDR_WIDTH(32)) dut (
      .forever_cpuclk(clk), .cpurst_b(rst_n),
      .regs_comp_lock(lock), .regs_comp_read(rd), .regs_comp_write(wr), .regs_comp_excut(ex),
      .ifu_pmp_req_vld(ifu_vld), .ifu_pmp_req_rdy(ifu_req_rdy), .ifu_pmp_req_mach(ifu_mach),
      .ifu_pmp_req_hit(ifu_hit), .ifu_pmp_req_addr(ifu_addr),
      .ifu_pmp_rsp_vld(ifu_rsp_vld), .ifu_pmp_rsp_rdy(ifu_rsp_rdy), .ifu_pmp_rsp_deny(ifu_rsp_deny),
      .ifu_pmp_rsp_hit(ifu_rsp_hit), .ifu_pmp_rsp_idx(ifu_rsp_idx),
      .lsu_pmp_req_vld(lsu_vld), .lsu_pmp_req_rdy(lsu_req_rdy), .lsu_pmp_req_mach(lsu_mach),
      .lsu_pmp_req_hit(lsu_hit), .lsu_pmp_req_addr(lsu_addr), .lsu_pmp_req_st(lsu_st),
      .lsu_pmp_rsp_vld(lsu_rsp_vld), .lsu_pmp_rsp_rdy(lsu_rsp_rdy), .lsu_pmp_rsp_deny(lsu_rsp_deny),
      .lsu_pmp_rsp_hit(lsu_rsp_hit), .lsu_pmp_rsp_idx(lsu_rsp_idx),
      .fault_clr(fclr), .fault_vld(f_vld), .fault_src(f_src), .fault_st(f_st),
      .fault_no_hit(f_nh), .fault_idx(f_idx), .fault_addr(f_addr), .fault_ovf(f_ovf)
   );

   pa_pmp_chk_pipe #(.NUM_ENTRY(16), .ADDR_WIDTH(32)) dut16 (
      .forever_cpuclk(clk), .cpurst_b(rst_n),
      .regs_comp_lock(w_perm), .regs_comp_read(w_perm), .regs_comp_write(w_perm), .regs_comp_excut(w_perm),
      .ifu_pmp_req_vld(w_vld), .ifu_pmp_req_rdy(w_ifu_req_rdy), .ifu_pmp_req_mach(1'b0),
      .ifu_pmp_req_hit(w_hit), .ifu_pmp_req_addr(32'h0000_00AA),
      .ifu_pmp_rsp_vld(w_ifu_rsp_vld), .ifu_pmp_rsp_rdy(1'b1), .ifu_pmp_rsp_deny(w_ifu_rsp_deny),
      .ifu_pmp_rsp_hit(w_ifu_rsp_hit), .ifu_pmp_rsp_idx(w_ifu_rsp_idx),
      .lsu_pmp_req_vld(w_vld), .lsu_pmp_req_rdy(w_lsu_req_rdy), .lsu_pmp_req_mach(1'b0),
      .lsu_pmp_req_hit(w_hit), .lsu_pmp_req_addr(32'h0000_00BB), .lsu_pmp_req_st(1'b0),
      .lsu_pmp_rsp_vld(w_lsu_rsp_vld), .lsu_pmp_rsp_rdy(1'b1), .lsu_pmp_rsp_deny(w_lsu_rsp_deny),
      .lsu_pmp_rsp_hit(w_lsu_rsp_hit), .lsu_pmp_rsp_idx(w_lsu_rsp_idx),
      .fault_clr(1'b0), .fault_vld(w_f_vld), .fault_src(w_f_src), .fault_st(w_f_st),
      .fault_no_hit(w_f_nh), .fault_idx(w_f_idx), .fault_addr(w_f_addr), .fault_ovf(w_f_ovf)
   );

   // Reference model state
   bit        m_ivld, m_ideny, m_ihit;
   bit [2:0]  m_iidx;
   bit        m_lvld, m_ldeny, m_lhit;
   bit [2:0]  m_lidx;
   bit        m_fvld, m_fsrc, m_fst, m_fnh, m_fovf;
   bit [2:0]  m_fidx;
   bit [31:0] m_faddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      {m_ivld, m_ideny, m_ihit, m_iidx} = '0;
      {m_lvld, m_ldeny, m_lhit, m_lidx} = '0;
      {m_fvld, m_fsrc, m_fst, m_fnh, m_fovf, m_fidx, m_faddr} = '0;
   endtask

   // Permission rules stated directly: find the first matching region, then decide.
   function automatic void ref_eval(input bit is_lsu, input bit mach, input bit st,
                                    input logic [7:0] hit, output bit deny, output bit hf,
                                    output bit [2:0] idx);
      int first;
      bit perm;
      first = -1;
      for (int i = 0; i < 8; i++) if (hit[i] && first < 0) first = i;
      hf  = (first >= 0);
      idx = hf ? 3'(first) : 3'd0;
      if (!hf) deny = !mach;
      else begin
         perm = is_lsu ? (st ? wr[first] : rd[first]) : ex[first];
         deny = !perm && (!mach || lock[first]);
      end
   endfunction

   // Checks outputs mid-cycle against the model, then advances the model across one edge.
   task automatic tick();
      bit i_rdy, l_rdy, i_acc, l_acc, idn, ihf, ldn, lhf;
      bit [2:0] iix, lix;
      bit n_fvld, n_fsrc, n_fst, n_fnh, n_fovf;
      bit [2:0] n_fidx;
      bit [31:0] n_faddr;
      #4;
      i_rdy = !m_ivld || ifu_rsp_rdy;
      l_rdy = !m_lvld || lsu_rsp_rdy;
      chk("ifu_req_rdy", ifu_req_rdy, i_rdy);
      chk("ifu_rsp_vld", ifu_rsp_vld, m_ivld);
      if (m_ivld) begin
         chk("ifu_rsp_deny", ifu_rsp_deny, m_ideny);
         chk("ifu_rsp_hit", ifu_rsp_hit, m_ihit);
         chk("ifu_rsp_idx", ifu_rsp_idx, m_iidx);
      end
      chk("lsu_req_rdy", lsu_req_rdy, l_rdy);
      chk("lsu_rsp_vld", lsu_rsp_vld, m_lvld);
      if (m_lvld) begin
         chk("lsu_rsp_deny", lsu_rsp_deny, m_ldeny);
         chk("lsu_rsp_hit", lsu_rsp_hit, m_lhit);
         chk("lsu_rsp_idx", lsu_rsp_idx, m_lidx);
      end
      chk("fault_vld", f_vld, m_fvld);
      chk("fault_ovf", f_ovf, m_fovf);
      chk("fault_src", f_src, m_fsrc);
      chk("fault_st", f_st, m_fst);
      chk("fault_no_hit", f_nh, m_fnh);
      chk("fault_idx", f_idx, m_fidx);
      chk("fault_addr", f_addr, m_faddr);

      i_acc = ifu_vld && i_rdy;
      l_acc = lsu_vld && l_rdy;
      ref_eval(1'b0, ifu_mach, 1'b0, ifu_hit, idn, ihf, iix);
      ref_eval(1'b1, lsu_mach, lsu_st, lsu_hit, ldn, lhf, lix);
      {n_fvld, n_fsrc, n_fst, n_fnh, n_fovf, n_fidx, n_faddr} =
         {m_fvld, m_fsrc, m_fst, m_fnh, m_fovf, m_fidx, m_faddr};
      if (fclr) begin n_fvld = 0; n_fovf = 0; end
      // LSU deny is considered first so it wins a simultaneous capture
      if (l_acc && ldn) begin
         if (!n_fvld) begin
            n_fvld = 1; n_fsrc = 1; n_fst = lsu_st; n_fnh = !lhf; n_fidx = lix; n_faddr = lsu_addr;
         end else n_fovf = 1;
      end
      if (i_acc && idn) begin
         if (!n_fvld) begin
            n_fvld = 1; n_fsrc = 0; n_fst = 0; n_fnh = !ihf; n_fidx = iix; n_faddr = ifu_addr;
         end else n_fovf = 1;
      end
      @(posedge clk);
      #1;
      if (i_acc) begin m_ivld = 1; m_ideny = idn; m_ihit = ihf; m_iidx = iix; end
      else if (ifu_rsp_rdy) m_ivld = 0;
      if (l_acc) begin m_lvld = 1; m_ldeny = ldn; m_lhit = lhf; m_lidx = lix; end
      else if (lsu_rsp_rdy) m_lvld = 0;
      {m_fvld, m_fsrc, m_fst, m_fnh, m_fovf, m_fidx, m_faddr} =
         {n_fvld, n_fsrc, n_fst, n_fnh, n_fovf, n_fidx, n_faddr};
   endtask

   task automatic idle();
      ifu_vld = 0; lsu_vld = 0; fclr = 0;
   endtask

   typedef struct {
      bit       lsu;
      bit       mach;
      bit       st;
      bit [7:0] hit;
      bit [7:0] lock;
      bit [7:0] rd;
      bit [7:0] wr;
      bit [7:0] ex;
      bit       e_deny;
      bit       e_hit;
      bit [2:0] e_idx;
   } vec_t;

   vec_t vt[8];

   initial begin
      vt[0] = '{1, 0, 0, 8'b0001_0100, 8'h00, 8'b0001_0000, 8'h00, 8'h00, 1, 1, 3'd2};
      vt[1] = '{0, 1, 0, 8'b0000_1000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 3'd3};
      vt[2] = '{0, 1, 0, 8'b0000_1000, 8'h08, 8'h00, 8'h00, 8'h00, 1, 1, 3'd3};
      vt[3] = '{0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1, 0, 3'd0};
      vt[4] = '{0, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 3'd0};
      vt[5] = '{1, 1, 1, 8'b1000_0000, 8'h80, 8'hFF, 8'h00, 8'hFF, 1, 1, 3'd7};
      vt[6] = '{1, 0, 1, 8'b1000_0001, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1, 3'd0};
      vt[7] = '{0, 0, 0, 8'b0110_0000, 8'h00, 8'h00, 8'h00, 8'b0100_0000, 1, 1, 3'd5};

      rst_n = 0;
      lock = 0; rd = 0; wr = 0; ex = 0;
      ifu_vld = 0; ifu_mach = 0; ifu_rsp_rdy = 1; ifu_hit = 0; ifu_addr = 0;
      lsu_vld = 0; lsu_mach = 0; lsu_rsp_rdy = 1; lsu_st = 0; lsu_hit = 0; lsu_addr = 0;
      fclr = 0; w_perm = 0; w_hit = 0; w_vld = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ifu_rsp_vld", ifu_rsp_vld, 0);
      chk("rst_lsu_rsp_vld", lsu_rsp_vld, 0);
      chk("rst_fault_vld", f_vld, 0);
      chk("rst_fault_addr", f_addr, 0);
      rst_n = 1;
      tick();

      // Directed permission table
      foreach (vt[k]) begin
         lock = vt[k].lock; rd = vt[k].rd; wr = vt[k].wr; ex = vt[k].ex;
         ifu_rsp_rdy = 1; lsu_rsp_rdy = 1;
         if (vt[k].lsu) begin
            lsu_vld = 1; lsu_mach = vt[k].mach; lsu_st = vt[k].st; lsu_hit = vt[k].hit;
            lsu_addr = 32'h100 * k;
         end else begin
            ifu_vld = 1; ifu_mach = vt[k].mach; ifu_hit = vt[k].hit; ifu_addr = 32'h100 * k;
         end
         tick();
         idle();
         if (vt[k].lsu) begin
            chk($sformatf("vec%0d_vld", k), lsu_rsp_vld, 1);
            chk($sformatf("vec%0d_deny", k), lsu_rsp_deny, vt[k].e_deny);
            chk($sformatf("vec%0d_hit", k), lsu_rsp_hit, vt[k].e_hit);
            chk($sformatf("vec%0d_idx", k), lsu_rsp_idx, vt[k].e_idx);
         end else begin
            chk($sformatf("vec%0d_vld", k), ifu_rsp_vld, 1);
            chk($sformatf("vec%0d_deny", k), ifu_rsp_deny, vt[k].e_deny);
            chk($sformatf("vec%0d_hit", k), ifu_rsp_hit, vt[k].e_hit);
            chk($sformatf("vec%0d_idx", k), ifu_rsp_idx, vt[k].e_idx);
         end
         tick();
      end

      // LSU backpressure: first response held, regs changes ignored, second follows
      lsu_mach = 0; lsu_st = 0; rd = 8'h01; wr = 0; lock = 0;
      lsu_rsp_rdy = 0; lsu_vld = 1; lsu_hit = 8'h01; lsu_addr = 32'hA0;
      tick();
      lsu_hit = 8'h02; lsu_addr = 32'hA4; rd = 8'h00;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_req_rdy", lsu_req_rdy, 0);
         chk("bp_hold_vld", lsu_rsp_vld, 1);
         chk("bp_hold_deny", lsu_rsp_deny, 0);
         chk("bp_hold_idx", lsu_rsp_idx, 0);
      end
      lsu_rsp_rdy = 1;
      tick();
      lsu_vld = 0;
      chk("bp_next_vld", lsu_rsp_vld, 1);
      chk("bp_next_deny", lsu_rsp_deny, 1);
      chk("bp_next_idx", lsu_rsp_idx, 1);
      tick();
      chk("bp_drain_vld", lsu_rsp_vld, 0);

      // Fault record: first deny kept, second sets overflow; clear with a new deny
      fclr = 1; tick(); fclr = 0;
      ifu_vld = 1; ifu_mach = 0; ifu_hit = 0; ifu_addr = 32'h1000;
      tick();
      ifu_vld = 0;
      lsu_vld = 1; lsu_mach = 0; lsu_st = 1; lsu_hit = 8'h01; wr = 0; lsu_addr = 32'h2000;
      tick();
      lsu_vld = 0;
      tick();
      chk("fr_src", f_src, 0);
      chk("fr_addr", f_addr, 32'h1000);
      chk("fr_ovf", f_ovf, 1);
      fclr = 1; lsu_vld = 1; lsu_st = 1; lsu_hit = 8'h01; lsu_addr = 32'h3000;
      tick();
      idle();
      chk("frc_vld", f_vld, 1);
      chk("frc_src", f_src, 1);
      chk("frc_st", f_st, 1);
      chk("frc_addr", f_addr, 32'h3000);
      chk("frc_ovf", f_ovf, 0);

      // Simultaneous denies with an empty record; also top entry on 16-entry instance
      fclr = 1; tick(); fclr = 0;
      ifu_vld = 1; ifu_mach = 0; ifu_hit = 0; ifu_addr = 32'h4000;
      lsu_vld = 1; lsu_mach = 0; lsu_st = 0; lsu_hit = 0; lsu_addr = 32'h5000;
      w_vld = 1; w_hit = 16'h8000; w_perm = 16'h0000;
      tick();
      idle(); w_vld = 0;
      chk("sim_src", f_src, 1);
      chk("sim_addr", f_addr, 32'h5000);
      chk("sim_ovf", f_ovf, 1);
      chk("sim_no_hit", f_nh, 1);
      chk("w_ifu_idx", w_ifu_rsp_idx, 4'hF);
      chk("w_lsu_deny", w_lsu_rsp_deny, 1);
      chk("w_fault_vld", w_f_vld, 1);
      chk("w_fault_src", w_f_src, 1);
      chk("w_fault_idx", w_f_idx, 4'hF);
      chk("w_fault_ovf", w_f_ovf, 1);
      chk("w_fault_addr", w_f_addr, 32'hBB);
      tick();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         lock = 8'($urandom); rd = 8'($urandom); wr = 8'($urandom); ex = 8'($urandom);
         ifu_vld = ($urandom_range(0, 3) != 0);
         ifu_mach = 1'($urandom);
         ifu_hit = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         ifu_addr = $urandom;
         ifu_rsp_rdy = ($urandom_range(0, 9) < 7);
         lsu_vld = ($urandom_range(0, 3) != 0);
         lsu_mach = 1'($urandom);
         lsu_st = 1'($urandom);
         lsu_hit = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         lsu_addr = $urandom;
         lsu_rsp_rdy = ($urandom_range(0, 9) < 7);
         fclr = ($urandom_range(0, 15) == 0);
         tick();
      end

      // Reset while an IFU response is stalled
      idle(); lsu_rsp_rdy = 1;
      ifu_rsp_rdy = 0; ifu_vld = 1; ifu_mach = 0; ifu_hit = 0; ifu_addr = 32'h6000;
      tick();
      ifu_vld = 0;
      tick();
      #2 rst_n = 0;
      #1;
      chk("mid_rst_ifu_vld", ifu_rsp_vld, 0);
      chk("mid_rst_ifu_deny", ifu_rsp_deny, 0);
      chk("mid_rst_fault_vld", f_vld, 0);
      chk("mid_rst_fault_addr", f_addr, 0);
      chk("mid_rst_lsu_vld", lsu_rsp_vld, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      repeat (3) begin
         tick();
         chk("post_rst_req_rdy", ifu_req_rdy, 1);
         chk("post_rst_rsp_vld", ifu_rsp_vld, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pa_pmp_chk_pipe.md
Name: pa_pmp_chk_pipe

Overview:
Parametrised, registered PMP permission checker for NUM_ENTRY regions, serving the IFU and LSU through independent valid/ready channels.
Per request, the block resolves the matching entry by RISC-V static priority (lowest hit index wins). It then applies the lock, mode and R/W/X rules and returns the result one cycle later.
A sticky fault-record register captures the first denied access for the CSR/debug path.
It sits between the pmp address comparators and the IFU/LSU bus interfaces.

Parameters:
NUM_ENTRY, 8, number of PMP regions; legal range 2..16.
ADDR_WIDTH, 32, width of the request address captured in the fault record.
IDX_W, $clog2(NUM_ENTRY), derived localparam; entry index width.

Ports:
forever_cpuclk  in  1  block clock; all state updates on rising edge.
cpurst_b  in  1  asynchronous active-low reset.
regs_comp_lock  in  NUM_ENTRY  per-entry L bit.
regs_comp_read  in  NUM_ENTRY  per-entry R bit.
regs_comp_write  in  NUM_ENTRY  per-entry W bit.
regs_comp_excut  in  NUM_ENTRY  per-entry X bit.
ifu_pmp_req_vld  in  1  IFU request valid.
ifu_pmp_req_rdy  out  1  IFU request ready.
ifu_pmp_req_mach  in  1  1 = machine mode, 0 = user mode.
ifu_pmp_req_hit  in  NUM_ENTRY  per-entry address-match vector.
ifu_pmp_req_addr  in  ADDR_WIDTH  request address.
ifu_pmp_rsp_vld  out  1  IFU response valid.
ifu_pmp_rsp_rdy  in  1  IFU response accept.
ifu_pmp_rsp_deny  out  1  access denied.
ifu_pmp_rsp_hit  out  1  at least one entry matched.
ifu_pmp_rsp_idx  out  IDX_W  governing entry index; 0 when no hit.
lsu_pmp_req_vld, lsu_pmp_req_rdy, lsu_pmp_req_mach, lsu_pmp_req_hit, lsu_pmp_req_addr  as IFU.
lsu_pmp_req_st  in  1  1 = store, 0 = load.
lsu_pmp_rsp_vld, lsu_pmp_rsp_rdy, lsu_pmp_rsp_deny, lsu_pmp_rsp_hit, lsu_pmp_rsp_idx  as IFU.
fault_clr  in  1  single-cycle pulse that clears the fault record.
fault_vld  out  1  fault record valid.
fault_src  out  1  0 = IFU, 1 = LSU.
fault_st  out  1  store flag of the captured LSU fault; 0 for IFU faults.
fault_no_hit  out  1  captured deny was a no-hit user access.
fault_idx  out  IDX_W  governing entry of the captured fault.
fault_addr  out  ADDR_WIDTH  captured address.
fault_ovf  out  1  a further deny occurred while fault_vld = 1.

Behaviour:
- Reset (cpurst_b = 0, asynchronous): all registered outputs are 0. The fault record and the response registers are cleared. A request in flight is discarded, and no response is issued after reset is released.
- Governing entry: the lowest index i with req_hit[i] = 1. Higher-index hits are ignored. rsp_hit = |req_hit.
- IFU deny, hit case: (mach & lock[i] & !excut[i]) | (!mach & !excut[i]).
- LSU deny, hit case: define perm = st ? write[i] : read[i]. Then deny = (mach & lock[i] & !perm) | (!mach & !perm).
- No-hit case: deny = !mach. Machine mode is allowed; user mode is denied.
- Channel handshake, applied per channel independently with a one-entry output register:
  - req_rdy = !rsp_vld | rsp_rdy.
  - Accept = req_vld & req_rdy. The response registers load on accept, so rsp_vld rises the cycle after accept. Latency is 1.
  - If rsp_vld & !rsp_rdy, rsp_vld, rsp_deny, rsp_hit and rsp_idx hold stable and req_rdy = 0.
  - If the response is consumed and a new request is accepted in the same cycle, the new result loads with no bubble. Full throughput is 1 per cycle per channel.
  - rsp_vld clears when the response is consumed and no new request is accepted.
- The regs_comp_* inputs are sampled in the accept cycle only. Later changes do not alter a pending response.
- Fault record, updated on accept with deny = 1:
  - If fault_vld = 0: capture src, st, no_hit, idx, addr and set fault_vld.
  - If fault_vld = 1: the record holds and fault_ovf is set.
- Simultaneous IFU and LSU denies with fault_vld = 0: the LSU is captured and fault_ovf is set.
- fault_clr:
  - clears fault_vld and fault_ovf;
  - if a deny is accepted in the same cycle, that deny is captured and ovf = 0; if both channels deny in that cycle, the LSU is captured and ovf = 1.
  - Other fields retain their last value while fault_vld = 0.
- Index encoding: a priority encoder over NUM_ENTRY bits. No generate-time restriction beyond the legal range.

Test Plan:
1. Reset mid-operation: IFU response pending with rsp_rdy = 0; assert cpurst_b = 0 -> all outputs 0 immediately. After release, req_rdy = 1 and no stale rsp_vld.
2. Priority: LSU user load, hit = 8'b0001_0100, read[2] = 0, read[4] = 1 -> rsp_deny = 1, idx = 2, one cycle after accept.
3. Lock and mode: IFU machine mode, hit[3], excut[3] = 0, lock[3] = 0 -> deny = 0. With lock[3] = 1 -> deny = 1. No-hit user -> deny = 1, hit = 0. No-hit machine -> deny = 0.
4. Backpressure: LSU back-to-back requests with rsp_rdy low for 3 cycles -> first response held stable, req_rdy = 0. On rsp_rdy = 1, the next response is issued the following cycle; no loss or duplication.
5. Fault record: IFU deny at addr 0x1000 then LSU store deny at 0x2000 -> record shows src = 0, addr = 0x1000, ovf = 1. fault_clr together with an LSU deny at 0x3000 -> src = 1, st as driven, addr = 0x3000, ovf = 0.
6. Simultaneous denies with fault_vld = 0 -> LSU captured, ovf = 1. Repeat with NUM_ENTRY = 16, deny on entry 15 -> idx = 4'hF.
